sid_reg_writer: RTL and testbench

- Bus-master sequencer that turns queued register-write commands (voice, addr, data) into the tt_um_sid host write protocol on ui_in/uio_in.
- Replaces hand-timed bench tasks and any on-chip/FPGA host logic that configures tt_um_sid voices, ADSR and filter.
- Commands enter through a small FIFO with valid/ready handshake; one write is played out at a time with parameterised setup/strobe/recovery timing.

---
 rtl/sid_ctrl_pkg.sv | 43 ++++
 rtl/sid_reg_writer_if.sv | 30 +++
 rtl/sid_cmd_fifo.sv | 59 +++++
 rtl/sid_reg_writer.sv | 122 ++++++++++++
 tb/tb_sid_reg_writer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sid_ctrl_pkg.sv
// Shared definitions for the tt_um_sid register-write sequencer:
// register map, bus field positions, command record and FSM states.
package sid_ctrl_pkg;

  localparam logic [2:0] FREQ_LO  = 3'd0;
  localparam logic [2:0] FREQ_HI  = 3'd1;
  localparam logic [2:0] PW_LO    = 3'd2;
  localparam logic [2:0] PW_HI    = 3'd3;
  localparam logic [2:0] ATK_DEC  = 3'd4;
  localparam logic [2:0] SUS_REL  = 3'd5;
  localparam logic [2:0] WAV      = 3'd6;

  localparam logic [2:0] FC_LO    = 3'd0;
  localparam logic [2:0] FC_HI    = 3'd1;
  localparam logic [2:0] RES_FILT = 3'd2;
  localparam logic [2:0] MODE_VOL = 3'd3;

  localparam logic [1:0] VOICE_FILT = 2'd3;

  localparam int unsigned WE_BIT    = 7;
  localparam int unsigned VOICE_LSB = 3;

  typedef struct packed {
    logic [1:0] voice;
    logic [2:0] addr;
    logic [7:0] data;
  } sid_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RECOV
  } wr_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sid_reg_writer_if.sv
// Command handshake and tt_um_sid host bus of the register writer.
// The writer connects through the slave modport, its host through master.
interface sid_reg_writer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_voice;
  logic [2:0]    cmd_addr;
  logic [7:0]    cmd_data;
  logic          flush;
  logic [7:0]    bus_ui;
  logic [7:0]    bus_uio;
  logic          busy;
  logic          wr_done;
  logic [LW-1:0] level;

  modport master (
    output cmd_valid, cmd_voice, cmd_addr, cmd_data, flush,
    input  cmd_ready, bus_ui, bus_uio, busy, wr_done, level
  );

  modport slave (
    input  cmd_valid, cmd_voice, cmd_addr, cmd_data, flush,
    output cmd_ready, bus_ui, bus_uio, busy, wr_done, level
  );

endinterface

// File: rtl/sid_cmd_fifo.sv
// Synchronous command FIFO with flush; level carries an extra bit so
// full and empty are distinguishable with wrapping pointers.
module sid_cmd_fifo
  import sid_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  sid_cmd_t               push_data,
  input  logic                   pop,
  input  logic                   flush,
  output sid_cmd_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  sid_cmd_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  // flush overrides both sides so a same-edge accept or pop never lands
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sid_reg_writer.sv
// Plays queued (voice, addr, data) commands onto the tt_um_sid host bus
// with setup / strobe / recovery timing; all bus outputs are registered.
module sid_reg_writer
  import sid_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned RECOV_CYC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  sid_reg_writer_if.slave bus
);

  localparam int unsigned CW = $clog2(max3(SETUP_CYC, STROBE_CYC, RECOV_CYC)) + 1;
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] RECOV_LD  = CW'(RECOV_CYC - 1);

  wr_state_t             state;
  logic [CW-1:0]         cnt;
  logic                  we_q;
  logic                  wr_done_q;
  sid_cmd_t              cmd_q;
  sid_cmd_t              fifo_head;
  sid_cmd_t              push_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                  start;

  assign push_data = '{voice: bus.cmd_voice, addr: bus.cmd_addr, data: bus.cmd_data};

  sid_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.cmd_valid),
    .push_data (push_data),
    .pop       (start),
    .flush     (bus.flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // A new write begins from IDLE or on the final RECOV cycle (back-to-back)
  always_comb begin
    start = 1'b0;
    if (!fifo_empty && !bus.flush)
      start = (state == ST_IDLE) || ((state == ST_RECOV) && (cnt == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      wr_done_q <= 1'b0;
      cmd_q     <= '0;
    end else begin
      wr_done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            cmd_q <= fifo_head;
            cnt   <= SETUP_LD;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            we_q  <= 1'b1;
            cnt   <= STROBE_LD;
            state <= ST_STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            we_q  <= 1'b0;
            cnt   <= RECOV_LD;
            state <= ST_RECOV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RECOV: begin
          if (cnt == '0) begin
            wr_done_q <= 1'b1;
            if (start) begin
              cmd_q <= fifo_head;
              cnt   <= SETUP_LD;
              state <= ST_SETUP;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.bus_ui                      = '0;
    bus.bus_ui[WE_BIT]              = we_q;
    bus.bus_ui[VOICE_LSB +: 2]      = cmd_q.voice;
    bus.bus_ui[VOICE_LSB-1:0]       = cmd_q.addr;
  end

  assign bus.bus_uio   = cmd_q.data;
  assign bus.cmd_ready = !fifo_full;
  assign bus.level     = fifo_level;
  assign bus.wr_done   = wr_done_q;
  assign bus.busy      = (state != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_sid_reg_writer.sv
// Self-checking bench for sid_reg_writer: directed vector table, multi-cycle
// corner sequences and random traffic against a write-schedule model.
module tb_sid_reg_writer;
  import sid_ctrl_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int S = 1;
  localparam int T = 2;
  localparam int R = 1;
  localparam int P = S + T + R;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sid_reg_writer_if #(.DEPTH(DEPTH)) bif ();
  sid_reg_writer_if #(.DEPTH(DEPTH)) sif ();

  sid_reg_writer #(.DEPTH(DEPTH), .SETUP_CYC(S), .STROBE_CYC(T), .RECOV_CYC(R)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif));

  sid_reg_writer #(.DEPTH(DEPTH), .SETUP_CYC(3), .STROBE_CYC(1), .RECOV_CYC(2)) dut_sweep (
    .clk(clk), .rst_n(rst_n), .bus(sif));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending queue plus cycles remaining in the write being played out
  sid_cmd_t   mq[$];
  int         rem;
  sid_cmd_t   cur;
  logic       exp_done;
  logic       prev_we;
  int         we_len;
  int         last_w;
  logic [7:0] seen[$];

  typedef struct {
    logic       v;
    sid_cmd_t   c;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [2:0] lvl;
    logic       busy;
    logic       done;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic v, input logic [1:0] vo, input logic [2:0] ad,
                              input logic [7:0] da, input logic [7:0] ui, input logic [7:0] uio,
                              input logic [2:0] lvl, input logic busy, input logic done);
    vec_t r;
    r.v = v; r.c = '{voice: vo, addr: ad, data: da};
    r.ui = ui; r.uio = uio; r.lvl = lvl; r.busy = busy; r.done = done;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    int k;
    logic we;
    logic [21:0] exp, act;
    k  = P - rem;
    we = (rem > 0) && (k >= S) && (k < S + T);
    exp = {we, 2'b00, cur.voice, cur.addr, cur.data, (mq.size() < DEPTH), 3'(mq.size()),
           (rem > 0) || (mq.size() != 0), exp_done};
    act = {bif.bus_ui, bif.bus_uio, bif.cmd_ready, bif.level, bif.busy, bif.wr_done};
    check({tag, " model"}, 32'(act), 32'(exp));
  endtask

  task automatic monitor();
    logic w;
    w = bif.bus_ui[7];
    if (w) we_len++;
    if (w && !prev_we) seen.push_back(bif.bus_uio);
    if (!w && prev_we) begin
      last_w = we_len;
      we_len = 0;
    end
    prev_we = w;
  endtask

  task automatic step(input logic v, input sid_cmd_t c, input logic fl, input string tag);
    logic rdy, st;
    bif.cmd_valid = v;
    bif.cmd_voice = c.voice;
    bif.cmd_addr  = c.addr;
    bif.cmd_data  = c.data;
    bif.flush     = fl;
    rdy      = (mq.size() < DEPTH);
    st       = (mq.size() != 0) && !fl && (rem <= 1);
    exp_done = (rem == 1);
    @(posedge clk);
    if (st) begin
      cur = mq.pop_front();
      rem = P;
    end else if (rem > 0) begin
      rem--;
    end
    if (fl) mq.delete();
    else if (v && rdy) mq.push_back(c);
    #1;
    check_model(tag);
    monitor();
  endtask

  task automatic idle_inputs();
    bif.cmd_valid = 1'b0; bif.cmd_voice = '0; bif.cmd_addr = '0; bif.cmd_data = '0;
    bif.flush = 1'b0;
    sif.cmd_valid = 1'b0; sif.cmd_voice = '0; sif.cmd_addr = '0; sif.cmd_data = '0;
    sif.flush = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle_inputs();
    mq.delete();
    rem = 0; cur = '0; exp_done = 1'b0; prev_we = 1'b0; we_len = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check({tag, " ui"},    32'(bif.bus_ui),    32'h00);
    check({tag, " uio"},   32'(bif.bus_uio),   32'h00);
    check({tag, " busy"},  32'(bif.busy),      32'h0);
    check({tag, " done"},  32'(bif.wr_done),   32'h0);
    check({tag, " level"}, 32'(bif.level),     32'h0);
    check({tag, " ready"}, 32'(bif.cmd_ready), 32'h1);
  endtask

  task automatic run_table();
    tv.push_back(mk(1, 2'd0, ATK_DEC, 8'h99, 8'h00, 8'h00, 3'd1, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h04, 8'h99, 3'd0, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h84, 8'h99, 3'd0, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h84, 8'h99, 3'd0, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h04, 8'h99, 3'd0, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h04, 8'h99, 3'd0, 0, 1));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h04, 8'h99, 3'd0, 0, 0));
    tv.push_back(mk(1, VOICE_FILT, RES_FILT + 3'd1, 8'h0F, 8'h04, 8'h99, 3'd1, 1, 0));
    tv.push_back(mk(1, 2'd0, WAV, 8'h11, 8'h1B, 8'h0F, 3'd1, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h9B, 8'h0F, 3'd1, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h9B, 8'h0F, 3'd1, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h1B, 8'h0F, 3'd1, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h06, 8'h11, 3'd0, 1, 1));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h86, 8'h11, 3'd0, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h86, 8'h11, 3'd0, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h06, 8'h11, 3'd0, 1, 0));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h06, 8'h11, 3'd0, 0, 1));
    tv.push_back(mk(0, 2'd0, 3'd0, 8'h00, 8'h06, 8'h11, 3'd0, 0, 0));
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].v, tv[i].c, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d ui", i),    32'(bif.bus_ui),  32'(tv[i].ui));
      check($sformatf("vec%0d uio", i),   32'(bif.bus_uio), 32'(tv[i].uio));
      check($sformatf("vec%0d level", i), 32'(bif.level),   32'(tv[i].lvl));
      check($sformatf("vec%0d busy", i),  32'(bif.busy),    32'(tv[i].busy));
      check($sformatf("vec%0d done", i),  32'(bif.wr_done), 32'(tv[i].done));
    end
  endtask

  task automatic run_burst();
    sid_cmd_t cmds[6];
    int   idx, budget;
    logic saw_stall, acc;
    idx = 0; budget = 0; saw_stall = 1'b0;
    seen.delete();
    for (int i = 0; i < 6; i++) cmds[i] = '{voice: 2'(i), addr: 3'(i), data: 8'(8'hA0 + i)};
    while (idx < 6 && budget < 100) begin
      acc = (mq.size() < DEPTH);
      step(1'b1, cmds[idx], 1'b0, "burst");
      if (!bif.cmd_ready) saw_stall = 1'b1;
      if (acc) idx++;
      budget++;
    end
    check("burst accepted", 32'(idx), 32'd6);
    check("burst stall", 32'(saw_stall), 32'h1);
    for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b0, "burst drain");
    check("burst strobes", 32'(seen.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("burst data%0d", i), 32'(i < seen.size() ? seen[i] : 8'h00),
            32'(8'hA0 + i));
  endtask

  task automatic run_flush();
    seen.delete();
    step(1'b1, '{voice: 2'd1, addr: FREQ_LO, data: 8'h31}, 1'b0, "flq");
    step(1'b1, '{voice: 2'd1, addr: FREQ_HI, data: 8'h32}, 1'b0, "flq");
    step(1'b1, '{voice: 2'd1, addr: PW_LO,   data: 8'h33}, 1'b0, "flq");
    check("flush in strobe", 32'(bif.bus_ui[7]), 32'h1);
    step(1'b1, '{voice: 2'd2, addr: PW_HI, data: 8'h34}, 1'b1, "flush");
    check("flush level", 32'(bif.level), 32'h0);
    check("flush we held", 32'(bif.bus_ui[7]), 32'h1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, "flush drain");
    check("flush strobes", 32'(seen.size()), 32'd1);
    check("flush data", 32'(seen.size() > 0 ? seen[0] : 8'h00), 32'h31);
    check("flush width", 32'(last_w), 32'(T));
    check("flush idle", 32'(bif.busy), 32'h0);
  endtask

  task automatic run_async_reset();
    step(1'b1, '{voice: 2'd2, addr: WAV, data: 8'h5A}, 1'b0, "rw");
    step(1'b0, '0, 1'b0, "rw");
    step(1'b0, '0, 1'b0, "rw");
    check("rw pre we", 32'(bif.bus_ui[7]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw async we", 32'(bif.bus_ui[7]), 32'h0);
    do_reset("rw after");
  endtask

  task automatic run_random();
    sid_cmd_t c;
    for (int i = 0; i < 400; i++) begin
      c = sid_cmd_t'(13'($urandom));
      step($urandom_range(0, 99) < 60, c, $urandom_range(0, 39) == 0, "rand");
    end
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, "rand drain");
  endtask

  task automatic run_sweep();
    logic [7:0] sui[24];
    logic [7:0] suio[24];
    logic       sdone[24];
    int chg_a, chg_b, we_a, we_b, d_a, d_b, we_cnt;
    chg_a = -100; chg_b = -100; we_a = -100; we_b = -100; d_a = -100; d_b = -100; we_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      sif.cmd_valid = (i < 2);
      sif.cmd_voice = (i == 0) ? 2'd0 : 2'd1;
      sif.cmd_addr  = (i == 0) ? FREQ_HI : PW_LO;
      sif.cmd_data  = (i == 0) ? 8'hC1 : 8'hC2;
      @(posedge clk);
      #1;
      sui[i] = sif.bus_ui; suio[i] = sif.bus_uio; sdone[i] = sif.wr_done;
    end
    sif.cmd_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (suio[i] == 8'hC1 && chg_a < 0) chg_a = i;
      if (suio[i] == 8'hC2 && chg_b < 0) chg_b = i;
      if (sui[i][7]) begin
        we_cnt++;
        if (suio[i] == 8'hC1 && we_a < 0) we_a = i;
        if (suio[i] == 8'hC2 && we_b < 0) we_b = i;
      end
      if (sdone[i]) begin
        if (d_a < 0) d_a = i;
        else if (d_b < 0) d_b = i;
      end
    end
    check("sweep bus latency", 32'(chg_a), 32'd1);
    check("sweep setup a", 32'(we_a - chg_a), 32'd3);
    check("sweep setup b", 32'(we_b - chg_b), 32'd3);
    check("sweep we cycles", 32'(we_cnt), 32'd2);
    check("sweep period", 32'(chg_b - chg_a), 32'd6);
    check("sweep done gap", 32'(d_b - d_a), 32'd6);
    check("sweep we ui", 32'(we_a >= 0 ? sui[we_a] : 8'h00), 32'h81);
  endtask

  initial begin
    do_reset("reset");
    run_table();
    run_burst();
    run_flush();
    run_async_reset();
    run_random();
    run_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
